// File: rtl/mem_if.sv
// mem_if: strobe/address/data bundle between controller and data-memory responder
interface mem_if;
  logic mem_read;
  logic mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic mem_ready;
  logic mem_busy;
  logic mem_err;
  modport master(output mem_read, mem_write, addr, wdata, input rdata, mem_ready, mem_busy, mem_err);
  modport slave(input mem_read, mem_write, addr, wdata, output rdata, mem_ready, mem_busy, mem_err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: edge-triggered word memory with wait states; MEM_RANGE_CHECK_EN adds sticky out-of-range error
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int ADDR_BITS = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic rd_q, wr_q, rd_rise, wr_rise, req, oob_in;
  logic op_wr, oob, err;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] wd, rdata;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
`ifdef MEM_RANGE_CHECK_EN
  assign oob_in = |bus.addr[31:ADDR_BITS];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_BITS];
  assign oob_in = 1'b0;
`endif
  // request edges and next state; a simultaneous read+write edge is a write
  always_comb begin
    rd_rise = bus.mem_read & ~rd_q;
    wr_rise = bus.mem_write & ~wr_q;
    req = rd_rise | wr_rise;
    state_nx = state;
    case (state)
      IDLE: state_nx = !req ? IDLE : (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT: state_nx = (cnt == 4'(WAIT_CYCLES - 1)) ? ACCESS : WAIT;
      ACCESS: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state, strobe history, request latches, read data and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
      op_wr <= 1'b0;
      oob <= 1'b0;
      idx <= '0;
      wd <= '0;
    end else begin
      state <= state_nx;
      rd_q <= bus.mem_read;
      wr_q <= bus.mem_write;
      cnt <= (state == WAIT) ? cnt + 4'd1 : '0;
      if (state == IDLE && req) begin
        op_wr <= wr_rise;
        oob <= oob_in;
        idx <= bus.addr[ADDR_BITS-1:0];
        wd <= bus.wdata;
      end
      if (state == ACCESS && !op_wr) rdata <= oob ? '0 : mem[idx];
      if (state == ACCESS && oob) err <= 1'b1;
    end
  end
  // array write; storage itself is never cleared
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && op_wr && !oob) mem[idx] <= wd;
  end
  assign bus.rdata = rdata;
  assign bus.mem_ready = (state == DONE);
  assign bus.mem_busy = (state == WAIT) || (state == ACCESS);
  assign bus.mem_err = err;
endmodule
